// File: rtl/preg_free_list_if.sv
// Interface bundling the rename/commit side of the physical register free list.
// master: rename + ROB commit logic driving requests; slave: the free list itself.
interface preg_free_list_if #(
  parameter int unsigned PREG_WIDTH = 7
);
  logic                  i_alloc_req;
  logic                  o_alloc_valid;
  logic [PREG_WIDTH-1:0] o_alloc_preg;
  logic                  i_free_valid;
  logic [PREG_WIDTH-1:0] i_free_preg;
  logic                  i_checkpoint;
  logic                  i_mispredict;
  logic                  o_empty;
  logic [PREG_WIDTH:0]   o_count;
  logic                  o_overflow;

  modport master (
    output i_alloc_req, i_free_valid, i_free_preg, i_checkpoint, i_mispredict,
    input  o_alloc_valid, o_alloc_preg, o_empty, o_count, o_overflow
  );

  modport slave (
    input  i_alloc_req, i_free_valid, i_free_preg, i_checkpoint, i_mispredict,
    output o_alloc_valid, o_alloc_preg, o_empty, o_count, o_overflow
  );
endinterface

// File: rtl/preg_free_list.sv
// Circular FIFO of free physical register numbers between ROB commit and rename.
// One pop per cycle for rename, one push per cycle from commit, and a single
// checkpoint of the read pointer for one-cycle branch mispredict recovery.
// Optional feature: define FL_BYPASS_EN to hand a freed preg straight to rename
// when the list is empty (adds a combinational commit -> rename path).
module preg_free_list #(
  parameter int unsigned PREG_WIDTH = 7,
  parameter int unsigned ARCH_REGS  = 32
) (
  input logic               clk,
  input logic               reset,
  preg_free_list_if.slave   fl
);
  localparam int unsigned FlDepth  = 2 ** PREG_WIDTH;
  localparam int unsigned MaxCount = FlDepth - ARCH_REGS;

  logic [PREG_WIDTH-1:0] mem_q [FlDepth];
  logic [PREG_WIDTH-1:0] head_q, head_d;
  logic [PREG_WIDTH-1:0] tail_q, tail_d;
  logic [PREG_WIDTH-1:0] ckpt_q, ckpt_d;
  logic [PREG_WIDTH-1:0] count;
  logic                  overflow_q, overflow_d;
  logic                  empty, full, free_req, bypass, bypass_take, pop, push;

  // Pointer arithmetic, handshake decode and outputs.
  always_comb begin
    count    = tail_q - head_q;
    empty    = (count == '0);
    full     = (count == PREG_WIDTH'(MaxCount));
    free_req = fl.i_free_valid && (fl.i_free_preg != '0);
`ifdef FL_BYPASS_EN
    bypass   = empty && free_req;
`else
    bypass   = 1'b0;
`endif
    // Mispredict blocks allocation so the restored head is not disturbed.
    fl.o_alloc_valid = !fl.i_mispredict && (!empty || bypass);
    fl.o_alloc_preg  = bypass ? fl.i_free_preg : mem_q[head_q];
    fl.o_empty       = empty;
    fl.o_count       = {1'b0, count};
    fl.o_overflow    = overflow_q;

    pop         = fl.i_alloc_req && !fl.i_mispredict && !empty;
    bypass_take = bypass && fl.i_alloc_req && !fl.i_mispredict;
    // A same-cycle pop frees a slot, so a push at full is still accepted then.
    push        = free_req && !bypass_take && (!full || pop);
    overflow_d  = overflow_q | (free_req && full && !pop);

    head_d = fl.i_mispredict ? ckpt_q : head_q + PREG_WIDTH'(pop);
    tail_d = tail_q + PREG_WIDTH'(push);
    // Snapshot includes this cycle's pop so the branch keeps its own preg.
    ckpt_d = (fl.i_checkpoint && !fl.i_mispredict) ? head_q + PREG_WIDTH'(pop) : ckpt_q;
  end

  // Pointer and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= PREG_WIDTH'(MaxCount);
      ckpt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      ckpt_q     <= ckpt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage: reset preloads every unmapped preg, commit writes at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FlDepth; i++) begin
        mem_q[i] <= (i < MaxCount) ? PREG_WIDTH'(ARCH_REGS + i) : '0;
      end
    end else if (push) begin
      mem_q[tail_q] <= fl.i_free_preg;
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for preg_free_list (PREG_WIDTH 7, ARCH_REGS 32).
module tb_preg_free_list;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  preg_free_list_if #(.PREG_WIDTH(7)) fl_if ();

  preg_free_list #(.PREG_WIDTH(7), .ARCH_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fl_if.i_alloc_req  = 1'b0;
    fl_if.i_free_valid = 1'b0;
    fl_if.i_free_preg  = '0;
    fl_if.i_checkpoint = 1'b0;
    fl_if.i_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic alloc(input int n);
    for (int i = 0; i < n; i++) begin
      fl_if.i_alloc_req = 1'b1;
      tick();
    end
    idle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_valid", fl_if.o_alloc_valid, 1);
    check("rst_preg", fl_if.o_alloc_preg, 32);
    check("rst_count", fl_if.o_count, 96);
    check("rst_empty", fl_if.o_empty, 0);
    check("rst_ovf", fl_if.o_overflow, 0);

    // Drain in order: 32..127
    for (int i = 0; i < 96; i++) begin
      fl_if.i_alloc_req = 1'b1;
      #1;
      check("drain_preg", fl_if.o_alloc_preg, 32 + i);
      tick();
    end
    idle();
    #1;
    check("drained_empty", fl_if.o_empty, 1);
    check("drained_count", fl_if.o_count, 0);
    check("drained_valid", fl_if.o_alloc_valid, 0);

    // Alloc while empty leaves head alone
    alloc(1);
    check("empty_alloc_count", fl_if.o_count, 0);

    // Free of preg 40 into an empty list with a pending alloc
    fl_if.i_alloc_req  = 1'b1;
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd40;
    #1;
`ifdef FL_BYPASS_EN
    check("bypass_valid", fl_if.o_alloc_valid, 1);
    check("bypass_preg", fl_if.o_alloc_preg, 40);
    tick();
    idle();
    #1;
    check("bypass_count", fl_if.o_count, 0);
    check("bypass_empty", fl_if.o_empty, 1);
`else
    check("nobypass_valid", fl_if.o_alloc_valid, 0);
    tick();
    idle();
    #1;
    check("nobypass_count", fl_if.o_count, 1);
    check("nobypass_preg", fl_if.o_alloc_preg, 40);
    check("nobypass_valid2", fl_if.o_alloc_valid, 1);
`endif

    // Alloc + free at count 96: count unchanged, freed preg comes out after the rest
    do_reset();
    fl_if.i_alloc_req  = 1'b1;
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd5;
    tick();
    idle();
    #1;
    check("allocfree_count", fl_if.o_count, 96);
    check("allocfree_ovf", fl_if.o_overflow, 0);
    alloc(95);
    check("allocfree_preg", fl_if.o_alloc_preg, 5);
    check("allocfree_count2", fl_if.o_count, 1);

    // Checkpoint / mispredict recovery
    do_reset();
    alloc(3);
    check("ck_pre_preg", fl_if.o_alloc_preg, 35);
    fl_if.i_alloc_req  = 1'b1;
    fl_if.i_checkpoint = 1'b1;
    tick();
    idle();
    alloc(2);
    check("ck_spec_preg", fl_if.o_alloc_preg, 38);
    fl_if.i_mispredict = 1'b1;
    #1;
    check("mp_valid_forced", fl_if.o_alloc_valid, 0);
    tick();
    idle();
    #1;
    check("mp_preg", fl_if.o_alloc_preg, 36);
    check("mp_count", fl_if.o_count, 92);

    // Mispredict with alloc and free(9): no pop, head restored, free pushed
    alloc(2);
    check("mp2_pre_count", fl_if.o_count, 90);
    fl_if.i_mispredict = 1'b1;
    fl_if.i_alloc_req  = 1'b1;
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd9;
    tick();
    idle();
    #1;
    check("mp2_preg", fl_if.o_alloc_preg, 36);
    check("mp2_count", fl_if.o_count, 93);
    alloc(92);
    check("mp2_tail_preg", fl_if.o_alloc_preg, 9);
    check("mp2_tail_count", fl_if.o_count, 1);

    // Free of preg 0 is ignored; free at full overflows and sticks
    do_reset();
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd0;
    tick();
    idle();
    #1;
    check("free0_count", fl_if.o_count, 96);
    check("free0_ovf", fl_if.o_overflow, 0);
    alloc(1);
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd0;
    tick();
    idle();
    #1;
    check("free0_count95", fl_if.o_count, 95);
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd3;
    tick();
    idle();
    #1;
    check("refill_count", fl_if.o_count, 96);
    check("refill_ovf", fl_if.o_overflow, 0);
    fl_if.i_free_valid = 1'b1;
    fl_if.i_free_preg  = 7'd7;
    tick();
    idle();
    #1;
    check("ovf_count", fl_if.o_count, 96);
    check("ovf_set", fl_if.o_overflow, 1);
    alloc(3);
    check("ovf_sticky", fl_if.o_overflow, 1);
    check("ovf_count93", fl_if.o_count, 93);
    do_reset();
    check("ovf_cleared", fl_if.o_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
